// File: rtl/fifo_wr_ctrl_pkg.sv
// rtl/fifo_wr_ctrl_pkg.sv - shared constants and Gray helpers for the async FIFO controllers
//
// Holds the default geometry of the asynchronous FIFO so that the write-side
// and read-side pointer controllers agree on it. It also provides a
// binary-to-Gray helper that both controllers use to build the pointer they
// send across the clock boundary.
//
// Contents
//   DEF_FIFO_DEPTH   : default number of FIFO entries (2**(DEF_P_SIZE-1))
//   DEF_P_SIZE       : default pointer width, including the wrap bit
//   DEF_AFULL_THRESH : default almost-full fill level
//   bin2gray()       : binary to reflected Gray code, 32-bit wide; callers
//                      cast the result down to their pointer width

package fifo_wr_ctrl_pkg;

    localparam int DEF_FIFO_DEPTH   = 8;
    localparam int DEF_P_SIZE       = 4;
    localparam int DEF_AFULL_THRESH = 6;

    // Adjacent binary values map to Gray codes that differ in exactly one
    // bit, so a pointer sampled mid-change in the other domain is off by at
    // most one position.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - parameterized Gray-to-binary converter (XOR prefix)
//
// Converts a Gray-coded pointer back to plain binary so that it can be used
// in subtraction. Each binary bit is the XOR of its Gray bit and all of the
// more-significant Gray bits. The write controller and the read controller
// both use this block.
//
// Parameters
//   WIDTH   : code width in bits
// Ports
//   gray_i  : Gray-coded input value
//   bin_o   : equivalent binary value (combinational)

module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // The top bit is copied unchanged. Each lower bit folds in the running
    // XOR of the bits above it. The chain is unrolled into plain XOR gates.
    always_comb begin
        bin_o = '0;
        bin_o[WIDTH-1] = gray_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin_o[i] = bin_o[i+1] ^ gray_i[i];
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, full/overflow and fill-level control for an async FIFO
//
// Keeps the binary write pointer and its Gray copy for the write side of a
// dual-clock FIFO. From the read pointer that has already been synchronized
// into this domain, it derives the full flag, a sticky overflow flag, and
// (optionally) a pessimistic fill level with an almost-full flag.
//
// Build option
//   FIFO_WR_CTRL_LEVEL_EN : when defined, W_LEVEL and AFULL are computed
//                           using a gray2bin instance. When undefined, both
//                           outputs are tied to 0 and the ports stay present.
//
// Parameters
//   FIFO_DEPTH   : number of FIFO entries, must equal 2**(P_SIZE-1)
//   P_SIZE       : pointer width, including the wrap bit
//   AFULL_THRESH : fill level at which AFULL asserts (1..FIFO_DEPTH)
//
// Ports
//   W_CLK    in   write-domain clock
//   W_RST    in   asynchronous active-high reset
//   W_INC    in   write request
//   OVF_CLR  in   clears the sticky OVERFLOW flag
//   wq2_rptr in   Gray read pointer, already synchronized into W_CLK
//   FULL     out  registered full flag
//   WCLKEN   out  memory write enable (W_INC & ~FULL), combinational
//   waddr    out  memory write address (low bits of the binary pointer)
//   wptr     out  registered Gray write pointer, sent to the read domain
//   OVERFLOW out  sticky: a write was attempted while full
//   W_LEVEL  out  registered, pessimistic fill level
//   AFULL    out  registered almost-full flag

module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int P_SIZE       = DEF_P_SIZE,
    parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
    input  logic              W_CLK,
    input  logic              W_RST,
    input  logic              W_INC,
    input  logic              OVF_CLR,
    input  logic [P_SIZE-1:0] wq2_rptr,
    output logic              FULL,
    output logic              WCLKEN,
    output logic [P_SIZE-2:0] waddr,
    output logic [P_SIZE-1:0] wptr,
    output logic              OVERFLOW,
    output logic [P_SIZE-1:0] W_LEVEL,
    output logic              AFULL
);

    // Catch an inconsistent geometry at elaboration rather than as a
    // silently wrong full flag later on.
    if (FIFO_DEPTH != (1 << (P_SIZE - 1))) begin : g_bad_depth
        $error("fifo_wr_ctrl: FIFO_DEPTH must equal 2**(P_SIZE-1)");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > FIFO_DEPTH)) begin : g_bad_thresh
        $error("fifo_wr_ctrl: AFULL_THRESH must lie in 1..FIFO_DEPTH");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [P_SIZE-1:0] wbin_q, wbin_d;
    logic [P_SIZE-1:0] wptr_q, wptr_d;
    logic              full_q, full_d;
    logic              ovf_q,  ovf_d;

    logic              accept;
    logic [P_SIZE-1:0] rptr_full_cmp;

    // A write is taken only when there is room. A rejected request leaves
    // the pointers unchanged, so a write attempted while full never
    // corrupts the memory.
    assign accept = W_INC & ~full_q;
    assign wbin_d = wbin_q + P_SIZE'(accept);
    assign wptr_d = P_SIZE'(bin2gray(32'(wbin_d)));

    // The FIFO is full when the write pointer has lapped the read pointer
    // by exactly one pass. In Gray code, that means the two MSBs are
    // inverted and all the lower bits are equal.
    assign rptr_full_cmp = {~wq2_rptr[P_SIZE-1:P_SIZE-2], wq2_rptr[P_SIZE-3:0]};
    assign full_d        = (wptr_d == rptr_full_cmp);

    // Set has priority over clear: an overflow that coincides with the
    // clear strobe must not be lost.
    assign ovf_d = (W_INC & full_q) | (ovf_q & ~OVF_CLR);

    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            wbin_q <= '0;
            wptr_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wbin_q <= wbin_d;
            wptr_q <= wptr_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    assign FULL     = full_q;
    assign WCLKEN   = accept;
    assign waddr    = wbin_q[P_SIZE-2:0];
    assign wptr     = wptr_q;
    assign OVERFLOW = ovf_q;

    // ------------------------------------------------------------------
    // Optional fill level / almost-full
    // ------------------------------------------------------------------
`ifdef FIFO_WR_CTRL_LEVEL_EN
    logic [P_SIZE-1:0] rbin;
    logic [P_SIZE-1:0] level_q, level_d;
    logic              afull_q, afull_d;

    gray2bin #(
        .WIDTH (P_SIZE)
    ) u_rptr_g2b (
        .gray_i (wq2_rptr),
        .bin_o  (rbin)
    );

    // Modulo subtraction stays correct when either pointer wraps. The read
    // pointer is stale by the synchronizer delay, so the level can only
    // over-report, which is the safe direction for the writer.
    assign level_d = wbin_d - rbin;
    assign afull_d = (level_d >= P_SIZE'(AFULL_THRESH));

    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= afull_d;
        end
    end

    assign W_LEVEL = level_q;
    assign AFULL   = afull_q;
`else
    assign W_LEVEL = '0;
    assign AFULL   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl against an occupancy model

module tb_fifo_wr_ctrl;

    logic       W_CLK = 1'b0;
    logic       W_RST;
    logic       W_INC;
    logic       OVF_CLR;
    logic [3:0] wq2_rptr;
    logic       FULL;
    logic       WCLKEN;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       OVERFLOW;
    logic [3:0] W_LEVEL;
    logic       AFULL;

    int total = 0;
    int bad   = 0;

    // Model state. m_wr counts accepted writes modulo 16. Occupancy is
    // writes minus reads, and the FIFO is full at 8 entries.
    int m_wr    = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_ovf   = 0;
    int rd      = 0;

    fifo_wr_ctrl #(
        .FIFO_DEPTH   (8),
        .P_SIZE       (4),
        .AFULL_THRESH (6)
    ) dut (
        .W_CLK    (W_CLK),
        .W_RST    (W_RST),
        .W_INC    (W_INC),
        .OVF_CLR  (OVF_CLR),
        .wq2_rptr (wq2_rptr),
        .FULL     (FULL),
        .WCLKEN   (WCLKEN),
        .waddr    (waddr),
        .wptr     (wptr),
        .OVERFLOW (OVERFLOW),
        .W_LEVEL  (W_LEVEL),
        .AFULL    (AFULL)
    );

    always #5 W_CLK = ~W_CLK;

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n & 15);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        int lvl_exp;
        bit af_exp;
`ifdef FIFO_WR_CTRL_LEVEL_EN
        lvl_exp = m_level;
        af_exp  = (m_level >= 6);
`else
        lvl_exp = 0;
        af_exp  = 0;
`endif
        chk({ctx, ".waddr"},    32'(waddr),    32'(m_wr % 8));
        chk({ctx, ".wptr"},     32'(wptr),     32'(to_gray(m_wr)));
        chk({ctx, ".full"},     32'(FULL),     32'(m_full));
        chk({ctx, ".overflow"}, 32'(OVERFLOW), 32'(m_ovf));
        chk({ctx, ".level"},    32'(W_LEVEL),  32'(lvl_exp));
        chk({ctx, ".afull"},    32'(AFULL),    32'(af_exp));
    endtask

    task automatic model_reset();
        m_wr = 0; m_level = 0; m_full = 0; m_ovf = 0; rd = 0;
    endtask

    // Runs one clock cycle, starting and ending just after a falling edge.
    task automatic step(input bit winc, input bit clr, input int rptr_bin, input string ctx);
        bit acc;
        W_INC    = winc;
        OVF_CLR  = clr;
        wq2_rptr = to_gray(rptr_bin);
        #1;
        acc = winc && !m_full;
        chk({ctx, ".wclken"}, 32'(WCLKEN), 32'(acc));
        @(posedge W_CLK);
        m_ovf   = (winc && m_full) || (m_ovf && !clr);
        m_wr    = (m_wr + int'(acc)) & 15;
        m_level = (m_wr - rptr_bin) & 15;
        m_full  = (m_level == 8);
        @(negedge W_CLK);
        check_outputs(ctx);
    endtask

    initial begin
        W_RST = 1'b1; W_INC = 1'b0; OVF_CLR = 1'b0; wq2_rptr = 4'b0000;
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge W_CLK);
        @(negedge W_CLK);
        W_RST = 1'b0;

        // Fill from empty.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, "fill");
        chk("fill.wptr_1100", 32'(wptr), 32'h0000_000C);
        chk("fill.full_set",  32'(FULL), 32'd1);

        // Writes while full are dropped and set the sticky flag.
        step(1'b1, 1'b0, 0, "ovf1");
        step(1'b1, 1'b0, 0, "ovf2");
        chk("ovf.wptr_hold", 32'(wptr), 32'h0000_000C);
        step(1'b0, 1'b1, 0, "ovf_clr");
        chk("ovf.cleared", 32'(OVERFLOW), 32'd0);
        step(1'b1, 1'b1, 0, "ovf_set_wins");
        chk("ovf.set_wins", 32'(OVERFLOW), 32'd1);
        step(1'b0, 1'b1, 0, "ovf_clr2");

        // A single read frees a slot, and the next write wraps waddr to 0.
        step(1'b0, 1'b0, 1, "rd1");
        chk("rd1.waddr_wrap", 32'(waddr), 32'd0);
        step(1'b1, 1'b0, 1, "wrap_wr");

        // Reset asserted mid-burst takes effect without a clock edge.
        step(1'b1, 1'b0, 9, "burst");
        W_INC = 1'b1;
        #2 W_RST = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        W_INC = 1'b0;
        @(negedge W_CLK);
        W_RST = 1'b0;
        chk("post_rst.waddr", 32'(waddr), 32'd0);

        // 16 writes while the reader trails one cycle behind.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, m_wr, "track");
            chk("track.not_full", 32'(FULL), 32'd0);
        end
        chk("track.wptr_home", 32'(wptr), 32'd0);

        // Random traffic with a reader that stays within the legal window.
        rd = m_wr;
        for (int i = 0; i < 300; i++) begin
            if ((((m_wr - rd) & 15) > 0) && ($urandom_range(0, 99) < 45))
                rd = (rd + 1) & 15;
            step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 10), rd, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: number of FIFO entries; SHALL equal 2**(P_SIZE-1).
REQ-002 Parameter P_SIZE, default 4: pointer width, including the wrap bit.
REQ-003 Parameter AFULL_THRESH, default 6: fill level at which AFULL asserts; range 1..FIFO_DEPTH.
REQ-004 W_CLK  in  1  write-domain clock; the block SHALL have exactly one clock.
REQ-005 W_RST  in  1  reset; asynchronous, active-high.
REQ-006 W_INC  in  1  write request.
REQ-007 OVF_CLR  in  1  clears the sticky OVERFLOW flag.
REQ-008 wq2_rptr  in  P_SIZE  read pointer (Gray), already synchronized into W_CLK.
REQ-009 FULL  out  1  registered full flag.
REQ-010 WCLKEN  out  1  memory write enable, combinational: W_INC & ~FULL.
REQ-011 waddr  out  P_SIZE-1  memory write address: wbin[P_SIZE-2:0].
REQ-012 wptr  out  P_SIZE  registered Gray write pointer, sent to the read domain.
REQ-013 OVERFLOW  out  1  sticky flag: a write was attempted while full.
REQ-014 W_LEVEL  out  P_SIZE  registered, pessimistic fill level.
REQ-015 AFULL  out  1  registered almost-full flag.

Function
REQ-016 A write SHALL be accepted when W_INC=1 and FULL=0; wbin_next = wbin + accepted.
REQ-017 wgnext SHALL equal (wbin_next>>1) ^ wbin_next; wbin and wptr SHALL load wbin_next and wgnext on every W_CLK edge.
REQ-018 full_next SHALL be (wgnext == {~wq2_rptr[P_SIZE-1:P_SIZE-2], wq2_rptr[P_SIZE-3:0]}), and FULL SHALL register it with one cycle of latency.
REQ-019 With W_INC=1 and FULL=1: wbin, wptr and waddr SHALL hold, WCLKEN SHALL be 0, and OVERFLOW SHALL set on the next edge.
REQ-020 OVERFLOW SHALL clear on the edge after OVF_CLR=1; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-021 W_LEVEL SHALL register (wbin_next - gray2bin(wq2_rptr)) modulo 2**P_SIZE; the value stays correct across pointer wrap.
REQ-022 AFULL SHALL register (level_next >= AFULL_THRESH).
REQ-023 Pointers SHALL wrap from 2**P_SIZE-1 to 0 without any special handling; waddr wraps every FIFO_DEPTH writes.
REQ-024 A change on wq2_rptr SHALL affect FULL, W_LEVEL and AFULL on the next edge, with no further delay.

Reset
REQ-025 While W_RST=1: wbin=0, wptr=0, FULL=0, OVERFLOW=0, W_LEVEL=0, AFULL=0, and therefore waddr=0.
REQ-026 Reset asserted mid-burst SHALL clear all state immediately, with no clock required; the first write after release SHALL go to waddr 0.

Configuration
REQ-027 Macro FIFO_WR_CTRL_LEVEL_EN defined: the W_LEVEL and AFULL logic and the gray2bin instance are built as specified in REQ-021..022.
REQ-028 Macro FIFO_WR_CTRL_LEVEL_EN undefined: W_LEVEL and AFULL SHALL be tied to 0, the ports SHALL remain present, and all other behaviour SHALL be unchanged.

Structure
REQ-029 A shared package SHALL hold the default constants FIFO_DEPTH, P_SIZE and AFULL_THRESH, plus a bin2gray function for use by both read and write controllers.
REQ-030 The Gray-to-binary conversion SHALL live in a parameterized sub-module named gray2bin (width P_SIZE, XOR-prefix), reusable by the read side.

Verification (FIFO_DEPTH=8, P_SIZE=4, AFULL_THRESH=6, macro defined unless stated)
REQ-031 Assert W_RST mid-operation -> FULL=0, wptr=4'b0000, waddr=0, OVERFLOW=0 and W_LEVEL=0 with no clock edge.
REQ-032 wq2_rptr=0; 8 consecutive W_INC -> waddr 0..7, WCLKEN=1 each cycle; W_LEVEL reaches 8 and AFULL=1 from level 6; FULL=1 after the 8th write; wptr=4'b1100.
REQ-033 Full state, W_INC=1 for 2 cycles -> WCLKEN=0, wptr stays 4'b1100, OVERFLOW=1; OVF_CLR pulse -> OVERFLOW=0; OVF_CLR and overflow in the same cycle -> OVERFLOW=1.
REQ-034 Full state, wq2_rptr -> 4'b0001 -> FULL=0 and W_LEVEL=7 on the next edge; one write -> waddr=0 (wrapped) and FULL=1 again.
REQ-035 16 writes with wq2_rptr tracking one cycle behind -> wptr sequence follows the 4-bit Gray code and returns to 4'b0000; FULL never asserts.
REQ-036 Rebuild with macro undefined, repeat REQ-032 -> W_LEVEL=0 and AFULL=0 throughout; FULL and wptr identical to REQ-032.
